multicycle_reg_sequencer: RTL and testbench
===========================================

// Module: multicycle_reg_sequencer
// PURPOSE
//   Control FSM for the multicycle datapath. Sequences the write enables of the 32-bit
//   pipeline registers (PC, IR, A/B, ALUOut, MDR) and the register file, and drives the
//   memory read/write handshake. Sits between the instruction register and datapath stages.
//   Retires one instruction at a time and flags illegal opcodes and memory timeouts.
// PARAMETERS
//   OP_RTYPE     6'b100000  R-type ALU opcode
//   OP_LW        6'b001111  load word opcode
//   OP_SW        6'b011111  store word opcode
//   OP_BEQ       6'b010000  branch-if-equal opcode
//   MEM_TIMEOUT  16         max wait cycles for Mem_Ready in FETCH/MEM (>=2)
// PORTS
//   Clk          in   1   clock, all state changes on rising edge
//   Reset_n      in   1   asynchronous, active-low reset
//   Run          in   1   1 = fetch/execute instructions, 0 = halt after current instr
//   Instr_Op     in   6   opcode field from IR output
//   Zero         in   1   ALU zero flag (valid in EXEC)
//   Mem_Ready    in   1   memory ack, synchronous to Clk
//   PC_WE        out  1   PC write enable
//   PC_Sel       out  1   0 = PC+4, 1 = branch target
//   IR_WE        out  1   IR write enable
//   AB_WE        out  1   A/B operand register write enable
//   ALUOut_WE    out  1   ALUOut register write enable
//   MDR_WE       out  1   memory data register write enable
//   RF_WE        out  1   register file write enable
//   RF_WrSel     out  1   RF write data: 0 = ALUOut, 1 = MDR
//   Mem_Rd       out  1   memory read request
//   Mem_Wr       out  1   memory write request
//   Instr_Done   out  1   one-cycle pulse on last cycle of each retired instruction
//   Error        out  1   sticky: illegal opcode or memory timeout
//   Retired      out  16  retired-instruction count, wraps 16'hFFFF -> 0
//   State        out  3   current state encoding (debug)
// BEHAVIOUR
//   States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5. Reset -> IDLE, Retired=0, Error=0,
//   Op_q=0, wait counter=0; every enable/request output is 0 while Reset_n=0.
//   Enables/requests: decoded from State, Op_q, Zero, Mem_Ready. Change only after a rising edge.
//   Unlisted outputs are 0.
//   IDLE: Run=1 -> FETCH, Error cleared on that transition; else stay.
//   FETCH: Mem_Rd=1. When Mem_Ready=1: IR_WE=1, PC_WE=1 (PC_Sel=0), -> DECODE.
//   DECODE: AB_WE=1; Op_q <= Instr_Op. Next state depends on Instr_Op:
//     - R-type, LW, SW or BEQ -> EXEC.
//     - Any other value -> IDLE, Error <= 1, no Instr_Done.
//   EXEC: outputs and next state depend on Op_q:
//     - R-type: ALUOut_WE=1 -> WB.
//     - LW/SW: ALUOut_WE=1 -> MEM.
//     - BEQ: PC_WE=Zero, PC_Sel=1, Instr_Done=1 -> end.
//   MEM: LW asserts Mem_Rd; SW asserts Mem_Wr. Stay until Mem_Ready=1, then:
//     - LW: MDR_WE=1 -> WB.
//     - SW: Instr_Done=1 -> end.
//   WB: RF_WE=1, RF_WrSel = (Op_q==OP_LW), Instr_Done=1 -> end.
//   end: Retired increments on each Instr_Done. Next state is FETCH if Run=1, else IDLE.
//   Run is sampled only at end; deasserting mid-instruction never aborts.
//   Timeout: wait counter counts consecutive FETCH/MEM cycles with Mem_Ready=0.
//   The counter clears on every state change.
//   On the MEM_TIMEOUT-th wait cycle: -> IDLE, Error <= 1, no write enable that cycle.
//   Mem_Ready=1 on that same cycle wins: normal transition, no error.
//   Latency with Mem_Ready=1 on the first request cycle:
//     - R-type: 4 cycles. LW: 5 cycles. SW: 4 cycles. BEQ: 3 cycles.
//   Reset_n low mid-instruction: immediate return to IDLE, no partial pulse afterwards.
// TESTING
//   1. Reset, Run=1, R-type, Mem_Ready=1 -> IR_WE/PC_WE@c1, AB_WE@c2, ALUOut_WE@c3,
//      RF_WE+Instr_Done@c4, Retired=1.
//   2. LW with Mem_Ready delayed 3 cycles in MEM -> Mem_Rd held 4 cycles, MDR_WE on ack,
//      RF_WE with RF_WrSel=1 next cycle.
//   3. BEQ, Zero=1 then Zero=0 -> PC_WE=1,PC_Sel=1 in EXEC; second run PC_WE=0; both pulse
//      Instr_Done.
//   4. Opcode 6'b000001 -> DECODE->IDLE, Error=1, Retired unchanged.
//      Then Run toggled 0->1 -> Error=0, FETCH.
//   5. Mem_Ready held 0 in FETCH -> IDLE after 16 cycles, Error=1.
//      Repeat with ack on 16th cycle -> DECODE, Error=0.
//   6. Run dropped during SW MEM -> SW completes with Instr_Done, then IDLE.
//      Preload Retired=16'hFFFF, next retire -> 0.

Source files
------------

// File: rtl/multicycle_reg_sequencer_if.sv
// Control/handshake bundle between the multicycle sequencer and the datapath/memory.
// The sequencer takes the slave view; the datapath side (or a bench) takes the master view.
interface multicycle_reg_sequencer_if;
  logic        Run;
  logic [5:0]  Instr_Op;
  logic        Zero;
  logic        Mem_Ready;
  logic        PC_WE;
  logic        PC_Sel;
  logic        IR_WE;
  logic        AB_WE;
  logic        ALUOut_WE;
  logic        MDR_WE;
  logic        RF_WE;
  logic        RF_WrSel;
  logic        Mem_Rd;
  logic        Mem_Wr;
  logic        Instr_Done;
  logic        Error;
  logic [15:0] Retired;
  logic [2:0]  State;

  modport slave (
    input  Run, Instr_Op, Zero, Mem_Ready,
    output PC_WE, PC_Sel, IR_WE, AB_WE, ALUOut_WE, MDR_WE, RF_WE, RF_WrSel,
           Mem_Rd, Mem_Wr, Instr_Done, Error, Retired, State
  );

  modport master (
    output Run, Instr_Op, Zero, Mem_Ready,
    input  PC_WE, PC_Sel, IR_WE, AB_WE, ALUOut_WE, MDR_WE, RF_WE, RF_WrSel,
           Mem_Rd, Mem_Wr, Instr_Done, Error, Retired, State
  );
endinterface

// File: rtl/multicycle_reg_sequencer.sv
// Multicycle datapath control FSM: sequences pipeline-register and register-file write
// enables, runs the memory handshake, counts retired instructions and flags faults.
module multicycle_reg_sequencer #(
  parameter logic [5:0]  OP_RTYPE    = 6'b100000,
  parameter logic [5:0]  OP_LW       = 6'b001111,
  parameter logic [5:0]  OP_SW       = 6'b011111,
  parameter logic [5:0]  OP_BEQ      = 6'b010000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  multicycle_reg_sequencer_if.slave   bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  state_t              state_r, state_nxt_s, end_state_s;
  logic [5:0]          op_r, op_nxt_s;
  logic [WAIT_W-1:0]   wait_r, wait_nxt_s;
  logic                error_r, error_nxt_s;
  logic [15:0]         retired_r, retired_nxt_s;
  logic                timeout_s, mem_wait_s;
  logic pc_we_s, pc_sel_s, ir_we_s, ab_we_s, alu_we_s, mdr_we_s;
  logic rf_we_s, rf_wrsel_s, mem_rd_s, mem_wr_s, done_s;

  function automatic logic legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  // Run is only consulted when an instruction retires, so it never aborts one midway.
  assign end_state_s   = bus.Run ? ST_FETCH : ST_IDLE;
  assign timeout_s     = (wait_r == WAIT_LAST);
  assign mem_wait_s    = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !bus.Mem_Ready;
  assign retired_nxt_s = done_s ? (retired_r + 16'd1) : retired_r;

  // Next-state, enable/request decode and wait-counter update.
  always_comb begin
    state_nxt_s = state_r;
    op_nxt_s    = op_r;
    error_nxt_s = error_r;
    wait_nxt_s  = wait_r;
    pc_we_s  = 1'b0;  pc_sel_s   = 1'b0;  ir_we_s  = 1'b0;  ab_we_s  = 1'b0;
    alu_we_s = 1'b0;  mdr_we_s   = 1'b0;  rf_we_s  = 1'b0;  rf_wrsel_s = 1'b0;
    mem_rd_s = 1'b0;  mem_wr_s   = 1'b0;  done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.Run) begin
          state_nxt_s = ST_FETCH;
          error_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        mem_rd_s = 1'b1;
        if (bus.Mem_Ready) begin
          ir_we_s     = 1'b1;
          pc_we_s     = 1'b1;
          state_nxt_s = ST_DECODE;
        end else if (timeout_s) begin
          state_nxt_s = ST_IDLE;
          error_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        ab_we_s  = 1'b1;
        op_nxt_s = bus.Instr_Op;
        if (legal_op(bus.Instr_Op)) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
          error_nxt_s = 1'b1;
        end
      end
      ST_EXEC: begin
        case (op_r)
          OP_RTYPE: begin alu_we_s = 1'b1; state_nxt_s = ST_WB;  end
          OP_LW:    begin alu_we_s = 1'b1; state_nxt_s = ST_MEM; end
          OP_SW:    begin alu_we_s = 1'b1; state_nxt_s = ST_MEM; end
          OP_BEQ: begin
            pc_we_s     = bus.Zero;
            pc_sel_s    = 1'b1;
            done_s      = 1'b1;
            state_nxt_s = end_state_s;
          end
          default: begin state_nxt_s = ST_IDLE; error_nxt_s = 1'b1; end
        endcase
      end
      ST_MEM: begin
        mem_rd_s = (op_r == OP_LW);
        mem_wr_s = (op_r == OP_SW);
        if (bus.Mem_Ready) begin
          if (op_r == OP_LW) begin
            mdr_we_s    = 1'b1;
            state_nxt_s = ST_WB;
          end else if (op_r == OP_SW) begin
            done_s      = 1'b1;
            state_nxt_s = end_state_s;
          end else begin
            state_nxt_s = ST_IDLE;
            error_nxt_s = 1'b1;
          end
        end else if (timeout_s) begin
          state_nxt_s = ST_IDLE;
          error_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we_s     = 1'b1;
        rf_wrsel_s  = (op_r == OP_LW);
        done_s      = 1'b1;
        state_nxt_s = end_state_s;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    // Wait count is per-state: any transition restarts it.
    if (state_nxt_s != state_r) begin
      wait_nxt_s = '0;
    end else if (mem_wait_s) begin
      wait_nxt_s = wait_r + WAIT_ONE;
    end else begin
      wait_nxt_s = wait_r;
    end
  end

  // Sequencer state, latched opcode, wait counter, sticky error and retire count.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= ST_IDLE;
      op_r      <= 6'd0;
      wait_r    <= '0;
      error_r   <= 1'b0;
      retired_r <= 16'd0;
    end else begin
      state_r   <= state_nxt_s;
      op_r      <= op_nxt_s;
      wait_r    <= wait_nxt_s;
      error_r   <= error_nxt_s;
      retired_r <= retired_nxt_s;
    end
  end

  assign bus.PC_WE      = pc_we_s;
  assign bus.PC_Sel     = pc_sel_s;
  assign bus.IR_WE      = ir_we_s;
  assign bus.AB_WE      = ab_we_s;
  assign bus.ALUOut_WE  = alu_we_s;
  assign bus.MDR_WE     = mdr_we_s;
  assign bus.RF_WE      = rf_we_s;
  assign bus.RF_WrSel   = rf_wrsel_s;
  assign bus.Mem_Rd     = mem_rd_s;
  assign bus.Mem_Wr     = mem_wr_s;
  assign bus.Instr_Done = done_s;
  assign bus.Error      = error_r;
  assign bus.Retired    = retired_r;
  assign bus.State      = state_r;

endmodule

// File: tb/tb_multicycle_reg_sequencer.sv
// Directed bench for multicycle_reg_sequencer: hand-computed per-cycle control vectors.
module tb_multicycle_reg_sequencer;

  logic Clk;
  logic Reset_n;
  int   n_checks;
  int   n_errors;

  multicycle_reg_sequencer_if bus();

  multicycle_reg_sequencer dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_BEQ   = 6'b010000;

  // Control vector bit positions: {PC_WE,PC_Sel,IR_WE,AB_WE,ALUOut_WE,MDR_WE,RF_WE,RF_WrSel,Mem_Rd,Mem_Wr,Instr_Done}
  localparam logic [10:0] C_PCWE  = 11'b100_0000_0000;
  localparam logic [10:0] C_PCSEL = 11'b010_0000_0000;
  localparam logic [10:0] C_IRWE  = 11'b001_0000_0000;
  localparam logic [10:0] C_ABWE  = 11'b000_1000_0000;
  localparam logic [10:0] C_ALUWE = 11'b000_0100_0000;
  localparam logic [10:0] C_MDRWE = 11'b000_0010_0000;
  localparam logic [10:0] C_RFWE  = 11'b000_0001_0000;
  localparam logic [10:0] C_WRSEL = 11'b000_0000_1000;
  localparam logic [10:0] C_MRD   = 11'b000_0000_0100;
  localparam logic [10:0] C_MWR   = 11'b000_0000_0010;
  localparam logic [10:0] C_DONE  = 11'b000_0000_0001;
  localparam logic [10:0] C_NONE  = 11'b000_0000_0000;
  localparam logic [10:0] C_FETCH = C_MRD | C_IRWE | C_PCWE;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [10:0] ctl_now();
    return {bus.PC_WE, bus.PC_Sel, bus.IR_WE, bus.AB_WE, bus.ALUOut_WE, bus.MDR_WE,
            bus.RF_WE, bus.RF_WrSel, bus.Mem_Rd, bus.Mem_Wr, bus.Instr_Done};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [10:0] ctl, input logic [2:0] st);
    #1;
    check({tag, "_ctl"}, 32'(ctl_now()), 32'(ctl));
    check({tag, "_st"}, 32'(bus.State), 32'(st));
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    Reset_n       = 1'b0;
    bus.Run       = 1'b0;
    bus.Instr_Op  = 6'd0;
    bus.Zero      = 1'b0;
    bus.Mem_Ready = 1'b0;

    #8;
    look("rst", C_NONE, 3'd0);
    check("rst_retired", 32'(bus.Retired), 32'd0);
    check("rst_error", 32'(bus.Error), 32'd0);
    #4 Reset_n = 1'b1;
    step(); look("idle", C_NONE, 3'd0);

    // R-type, memory ready immediately: 4 cycles
    bus.Run = 1'b1; bus.Instr_Op = OP_RTYPE; bus.Mem_Ready = 1'b1;
    step(); look("r_c1", C_FETCH, 3'd1);
    step(); look("r_c2", C_ABWE, 3'd2);
    step(); look("r_c3", C_ALUWE, 3'd3);
    bus.Run = 1'b0;
    step(); look("r_c4", C_RFWE | C_DONE, 3'd5);
    step(); look("r_end", C_NONE, 3'd0);
    check("r_retired", 32'(bus.Retired), 32'd1);

    // LW with three wait cycles in MEM
    bus.Run = 1'b1; bus.Instr_Op = OP_LW;
    step(); look("lw_f", C_FETCH, 3'd1);
    bus.Run = 1'b0;
    step(); look("lw_d", C_ABWE, 3'd2);
    step(); look("lw_e", C_ALUWE, 3'd3);
    bus.Mem_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); look("lw_mwait", C_MRD, 3'd4);
    end
    step(); bus.Mem_Ready = 1'b1; look("lw_mack", C_MRD | C_MDRWE, 3'd4);
    step(); look("lw_wb", C_RFWE | C_WRSEL | C_DONE, 3'd5);
    step(); look("lw_end", C_NONE, 3'd0);
    check("lw_retired", 32'(bus.Retired), 32'd2);

    // BEQ taken then not taken, back to back
    bus.Run = 1'b1; bus.Instr_Op = OP_BEQ; bus.Zero = 1'b1;
    step(); look("beq1_f", C_FETCH, 3'd1);
    step(); look("beq1_d", C_ABWE, 3'd2);
    step(); look("beq1_e", C_PCWE | C_PCSEL | C_DONE, 3'd3);
    bus.Zero = 1'b0;
    step(); look("beq2_f", C_FETCH, 3'd1);
    check("beq1_retired", 32'(bus.Retired), 32'd3);
    step(); look("beq2_d", C_ABWE, 3'd2);
    bus.Run = 1'b0;
    step(); look("beq2_e", C_PCSEL | C_DONE, 3'd3);
    step(); look("beq2_end", C_NONE, 3'd0);
    check("beq2_retired", 32'(bus.Retired), 32'd4);

    // SW with Run dropped mid-instruction
    bus.Run = 1'b1; bus.Instr_Op = OP_SW;
    step(); look("sw_f", C_FETCH, 3'd1);
    step(); look("sw_d", C_ABWE, 3'd2);
    step(); look("sw_e", C_ALUWE, 3'd3);
    bus.Mem_Ready = 1'b0; bus.Run = 1'b0;
    step(); look("sw_mwait", C_MWR, 3'd4);
    step(); bus.Mem_Ready = 1'b1; look("sw_mack", C_MWR | C_DONE, 3'd4);
    step(); look("sw_end", C_NONE, 3'd0);
    check("sw_retired", 32'(bus.Retired), 32'd5);

    // Illegal opcode
    bus.Run = 1'b1; bus.Instr_Op = 6'b000001;
    step(); look("ill_f", C_FETCH, 3'd1);
    bus.Run = 1'b0;
    step(); look("ill_d", C_ABWE, 3'd2);
    step(); look("ill_idle", C_NONE, 3'd0);
    check("ill_error", 32'(bus.Error), 32'd1);
    check("ill_retired", 32'(bus.Retired), 32'd5);
    step(); look("ill_hold", C_NONE, 3'd0);

    // Fetch timeout: 16 wait cycles then IDLE with Error
    bus.Mem_Ready = 1'b0; bus.Run = 1'b1;
    step(); look("to_f1", C_MRD, 3'd1);
    check("to_err_clr", 32'(bus.Error), 32'd0);
    bus.Run = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      step(); look("to_wait", C_MRD, 3'd1);
    end
    step(); look("to_idle", C_NONE, 3'd0);
    check("to_error", 32'(bus.Error), 32'd1);

    // Ack on the 16th wait cycle wins over the timeout
    bus.Run = 1'b1; bus.Instr_Op = OP_RTYPE;
    step(); look("ack_f1", C_MRD, 3'd1);
    check("ack_err_clr", 32'(bus.Error), 32'd0);
    bus.Run = 1'b0;
    for (int i = 2; i <= 15; i++) begin
      step();
    end
    step(); bus.Mem_Ready = 1'b1; look("ack_f16", C_FETCH, 3'd1);
    step(); look("ack_d", C_ABWE, 3'd2);
    check("ack_error", 32'(bus.Error), 32'd0);
    step(); look("ack_e", C_ALUWE, 3'd3);
    step(); look("ack_wb", C_RFWE | C_DONE, 3'd5);
    step(); look("ack_end", C_NONE, 3'd0);
    check("ack_retired", 32'(bus.Retired), 32'd6);

    // Retire counter wrap
    force dut.retired_r = 16'hFFFF;
    #1;
    release dut.retired_r;
    step(); check("wrap_pre", 32'(bus.Retired), 32'h0000FFFF);
    bus.Run = 1'b1; bus.Instr_Op = OP_BEQ; bus.Zero = 1'b0;
    step(); look("wrap_f", C_FETCH, 3'd1);
    bus.Run = 1'b0;
    step(); look("wrap_d", C_ABWE, 3'd2);
    step(); look("wrap_e", C_PCSEL | C_DONE, 3'd3);
    step(); check("wrap_post", 32'(bus.Retired), 32'd0);

    // Reset in the middle of an instruction
    bus.Run = 1'b1; bus.Instr_Op = OP_RTYPE;
    step(); look("mrst_f", C_FETCH, 3'd1);
    step(); look("mrst_d", C_ABWE, 3'd2);
    #1 Reset_n = 1'b0;
    look("mrst_now", C_NONE, 3'd0);
    check("mrst_retired", 32'(bus.Retired), 32'd0);
    bus.Run = 1'b0;
    #2 Reset_n = 1'b1;
    step(); look("mrst_after", C_NONE, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
